// File: rtl/shift_xfer_ctrl.sv
// Sequencer for a WIDTH-bit bidirectional SIPO shift register: clear, shift WIDTH bits, capture.
// Optional build macro SHIFT_XFER_CHECK_EN adds chk_err (captured word vs. sent word compare).
module shift_xfer_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_dir,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             abort,
   input  logic [WIDTH-1:0] sr_par,
   output logic             sr_a,
   output logic             sr_dir,
   output logic             sr_en,
   output logic             sr_clr,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
`ifdef SHIFT_XFER_CHECK_EN
   output logic             chk_err,
`endif
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh_p0;
   logic             dir_p0;
`ifdef SHIFT_XFER_CHECK_EN
   logic [WIDTH-1:0] dat_p0;
`endif

   // Right shift enters at bit0, so the MSB must go first; left shift the reverse.
   function automatic logic next_bit(input logic [WIDTH-1:0] v, input logic d);
      return d ? v[WIDTH-1] : v[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v, input logic d);
      return d ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state    <= IDLE;
         cnt      <= '0;
         sr_a     <= 1'b0;
         sr_dir   <= 1'b0;
         sr_en    <= 1'b0;
         sr_clr   <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         tx_ready <= 1'b0;
`ifdef SHIFT_XFER_CHECK_EN
         chk_err  <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         sr_clr   <= 1'b0;
`ifdef SHIFT_XFER_CHECK_EN
         chk_err  <= 1'b0;
`endif
         if (state == IDLE) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            sr_en    <= 1'b0;
            if (tx_valid && tx_ready) begin
               sh_p0    <= tx_data;
               dir_p0   <= tx_dir;
`ifdef SHIFT_XFER_CHECK_EN
               dat_p0   <= tx_data;
`endif
               state    <= CLEAR;
               tx_ready <= 1'b0;
               busy     <= 1'b1;
               sr_clr   <= 1'b1;
            end
         end else if (abort) begin
            // Leave the register cleared so a half-shifted word is never observed.
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            sr_en    <= 1'b0;
            sr_clr   <= 1'b1;
         end else begin
            case (state)
               CLEAR: begin
                  cnt    <= '0;
                  state  <= SHIFT;
                  sr_en  <= 1'b1;
                  sr_dir <= dir_p0;
                  sr_a   <= next_bit(sh_p0, dir_p0);
                  sh_p0  <= advance(sh_p0, dir_p0);
               end
               SHIFT: begin
                  if (cnt == LAST) begin
                     state <= DONE;
                     sr_en <= 1'b0;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     sr_a  <= next_bit(sh_p0, dir_p0);
                     sh_p0 <= advance(sh_p0, dir_p0);
                  end
               end
               DONE: begin
                  rx_data  <= sr_par;
                  rx_valid <= 1'b1;
                  state    <= IDLE;
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
`ifdef SHIFT_XFER_CHECK_EN
                  chk_err  <= (sr_par != dat_p0);
`endif
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Bench for shift_xfer_ctrl with a behavioural SIPO register model and a transfer reference model.
module tb_shift_xfer_ctrl;

   logic       clk = 1'b0;
   logic       res_n, tx_dir, tx_valid, tx_ready, abort;
   logic [7:0] tx_data, sr_par, rx_data;
   logic       sr_a, sr_dir, sr_en, sr_clr, rx_valid, busy;
`ifdef SHIFT_XFER_CHECK_EN
   logic       chk_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_xfer_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .res_n(res_n), .tx_data(tx_data), .tx_dir(tx_dir),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .abort(abort), .sr_par(sr_par),
      .sr_a(sr_a), .sr_dir(sr_dir), .sr_en(sr_en), .sr_clr(sr_clr),
      .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SHIFT_XFER_CHECK_EN
      .chk_err(chk_err),
`endif
      .busy(busy)
   );

   // Shift register being controlled; bit3 can be forced stuck-at-0.
   logic [7:0] sreg   = 8'h00;
   logic       stuck3 = 1'b0;
   assign sr_par = stuck3 ? (sreg & 8'hF7) : sreg;
   always @(posedge clk) begin
      if (sr_clr)     sreg <= 8'h00;
      else if (sr_en) sreg <= sr_dir ? {sreg[6:0], sr_a} : {sr_a, sreg[7:1]};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: i-th serial bit sent is d[7-i] for right shift, d[i] for left shift.
   function automatic logic [7:0] model_seq(input logic [7:0] d, input logic dir);
      logic [7:0] s;
      for (int i = 0; i < 8; i++) s[i] = dir ? d[7-i] : d[i];
      return s;
   endfunction

   task automatic run_xfer(input logic [7:0] d, input logic dir, input logic [7:0] seq,
                           input logic hold, output int waited);
      logic [7:0] exp_rx;
      waited = 0;
      while (!tx_ready && waited < 30) begin
         @(negedge clk);
         waited++;
      end
      if (!tx_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      tx_data = d; tx_dir = dir; tx_valid = 1'b1;
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
      tx_data = 8'($urandom); tx_dir = 1'($urandom);
      chk("clear", {sr_clr, sr_en, busy, tx_ready}, 4'b1010);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("shift%0d_en_dir_a", i), {sr_en, sr_dir, sr_a}, {1'b1, dir, seq[i]});
         tx_data = 8'($urandom); tx_dir = 1'($urandom);
      end
      @(negedge clk);
      chk("done_en_rxv_busy", {sr_en, rx_valid, busy}, 3'b001);
      @(negedge clk);
      exp_rx = stuck3 ? (d & 8'hF7) : d;
      chk("rx_valid", rx_valid, 1'b1);
      chk("rx_data", rx_data, exp_rx);
      chk("rx_ready_busy", {tx_ready, busy}, 2'b10);
`ifdef SHIFT_XFER_CHECK_EN
      chk("chk_err", chk_err, exp_rx != d);
`endif
   endtask

   task automatic abort_xfer(input logic [7:0] d, input logic use_reset);
      int seen;
      int w;
      w = 0;
      while (!tx_ready && w < 30) begin
         @(negedge clk);
         w++;
      end
      tx_data = d; tx_dir = 1'b1; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("abort_in_shift", {sr_en, busy}, 2'b11);
      if (use_reset) res_n = 1'b0; else abort = 1'b1;
      @(negedge clk);
      if (use_reset) begin
         chk("rst_mid_outputs", {busy, sr_clr, sr_en, tx_ready, rx_valid}, 5'b01000);
         res_n = 1'b1;
      end else begin
         chk("abort_outputs", {busy, sr_clr, sr_en, tx_ready, rx_valid}, 5'b01010);
         abort = 1'b0;
      end
      @(negedge clk);
      chk("post_abort_clr_ready", {sr_clr, tx_ready}, 2'b01);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (rx_valid) seen++;
         @(negedge clk);
      end
      chk("no_rx_after_abort", seen, 0);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       dir;
      logic       hold;
      logic [7:0] seq;
   } vec_t;

   vec_t vt[4];
   int   waited;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{d: 8'hA5, dir: 1'b1, hold: 1'b0, seq: 8'b1010_0101};
      vt[1] = '{d: 8'h3C, dir: 1'b0, hold: 1'b0, seq: 8'b0011_1100};
      vt[2] = '{d: 8'h01, dir: 1'b1, hold: 1'b1, seq: 8'b1000_0000};
      vt[3] = '{d: 8'h80, dir: 1'b0, hold: 1'b0, seq: 8'b1000_0000};

      res_n = 1'b0; tx_valid = 1'b0; abort = 1'b0; tx_data = 8'h00; tx_dir = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_state", {busy, rx_valid, sr_clr, sr_en, tx_ready, rx_data},
          {5'b00100, 8'h00});
      res_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {tx_ready, sr_clr, busy}, 3'b100);

      abort = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_idle_ignored", {tx_ready, busy, sr_clr}, 3'b100);
      abort = 1'b0;

      for (int k = 0; k < 4; k++) begin
         run_xfer(vt[k].d, vt[k].dir, vt[k].seq, vt[k].hold, waited);
         if (k == 3) chk("b2b_no_wait", waited, 0);
      end

      abort_xfer(8'h5A, 1'b0);
      run_xfer(8'hFF, 1'b1, 8'hFF, 1'b0, waited);
      abort_xfer(8'hC3, 1'b1);
      run_xfer(8'hFF, 1'b0, 8'hFF, 1'b0, waited);

      for (int k = 0; k < 20; k++) begin
         logic [7:0] d;
         logic       dir, hold;
         d    = 8'($urandom);
         dir  = 1'($urandom);
         hold = (k != 19) ? 1'($urandom) : 1'b0;
         run_xfer(d, dir, model_seq(d, dir), hold, waited);
      end
      tx_valid = 1'b0;

`ifdef SHIFT_XFER_CHECK_EN
      stuck3 = 1'b1;
      run_xfer(8'hFF, 1'b1, 8'hFF, 1'b0, waited);
      stuck3 = 1'b0;
      run_xfer(8'hFF, 1'b1, 8'hFF, 1'b0, waited);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
